// File: rtl/slot_judge_if.sv
// Signal bundle between the three-reel sequencer and the reel datapath / display.
// The master side drives the stop/tick pulses and live reel counts; the slave
// side (the sequencer) returns reel gates, latched digits, result flags and score.
interface slot_judge_if;
    logic       i_stop;
    logic       i_tick;
    logic [3:0] i_cnt0;
    logic [3:0] i_cnt1;
    logic [3:0] i_cnt2;
    logic [2:0] o_run;
    logic [3:0] o_d0;
    logic [3:0] o_d1;
    logic [3:0] o_d2;
    logic       o_win;
    logic       o_pair;
    logic       o_ledr;
    logic [3:0] o_score_ones;
    logic [3:0] o_score_tens;

    modport master (
        output i_stop, i_tick, i_cnt0, i_cnt1, i_cnt2,
        input  o_run, o_d0, o_d1, o_d2, o_win, o_pair, o_ledr,
               o_score_ones, o_score_tens
    );

    modport slave (
        input  i_stop, i_tick, i_cnt0, i_cnt1, i_cnt2,
        output o_run, o_d0, o_d1, o_d2, o_win, o_pair, o_ledr,
               o_score_ones, o_score_tens
    );
endinterface

// File: rtl/slot_judge.sv
// Three-reel slot sequencer: stops reels left-to-right on successive stop
// pulses, latches the stopped digits, judges triple/pair, keeps a saturating
// 2-digit BCD score and drives a status LED that blinks on a jackpot.

// Per-reel lane: gates the reel counter and captures its digit on the stop cycle.
module slot_judge_reel (
    input  logic       clk,
    input  logic       rst,
    input  logic       spin,
    input  logic       stop_now,
    input  logic [3:0] cnt,
    output logic       run,
    output logic [3:0] digit
);
    // Dropping the gate in the stop cycle freezes the reel, so the captured
    // digit is exactly the one on display.
    assign run = spin & ~stop_now;

    // Capture the live count when this reel is the one being stopped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           digit <= 4'd0;
        else if (stop_now) digit <= cnt;
    end
endmodule

module slot_judge #(
    parameter int SCORE_PAIR   = 1,
    parameter int SCORE_TRIPLE = 1
) (
    input  logic       clk,
    input  logic       i_sclr,
    slot_judge_if.slave bus
);
    localparam int NUM_REELS = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SPIN3  = 3'd1,
        SPIN2  = 3'd2,
        SPIN1  = 3'd3,
        JUDGE  = 3'd4,
        RESULT = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [NUM_REELS-1:0]      spin_mask;
    logic [NUM_REELS-1:0]      stop_sel;
    logic [NUM_REELS-1:0]      run_v;
    logic [NUM_REELS-1:0][3:0] cnt_v;
    logic [NUM_REELS-1:0][3:0] dig_v;

    logic       win_q, pair_q, blink_q;
    logic [3:0] ones_q, tens_q;

    logic       triple, pair_only;
    logic [4:0] ones_sum, tens_sum_p, tens_sum_t;
    logic       ones_carry;
    logic [3:0] ones_p;
    logic [3:0] ones_nxt, tens_nxt;

    // State register.
    always_ff @(posedge clk or posedge i_sclr) begin
        if (i_sclr) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state plus which reels spin and which one is being stopped now.
    always_comb begin
        state_d   = state_q;
        spin_mask = '0;
        stop_sel  = '0;
        case (state_q)
            IDLE: begin
                if (bus.i_stop) state_d = SPIN3;
            end
            SPIN3: begin
                spin_mask   = 3'b111;
                stop_sel[0] = bus.i_stop;
                if (bus.i_stop) state_d = SPIN2;
            end
            SPIN2: begin
                spin_mask   = 3'b110;
                stop_sel[1] = bus.i_stop;
                if (bus.i_stop) state_d = SPIN1;
            end
            SPIN1: begin
                spin_mask   = 3'b100;
                stop_sel[2] = bus.i_stop;
                if (bus.i_stop) state_d = JUDGE;
            end
            JUDGE: begin
                state_d = RESULT;
            end
            RESULT: begin
                if (bus.i_stop) state_d = SPIN3;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cnt_v = {bus.i_cnt2, bus.i_cnt1, bus.i_cnt0};

    for (genvar k = 0; k < NUM_REELS; k++) begin : g_reel
        slot_judge_reel u_reel (
            .clk      (clk),
            .rst      (i_sclr),
            .spin     (spin_mask[k]),
            .stop_now (stop_sel[k]),
            .cnt      (cnt_v[k]),
            .run      (run_v[k]),
            .digit    (dig_v[k])
        );
    end

    // Outcome of the latched digits; raw 4-bit compare, no BCD check needed.
    always_comb begin
        triple    = (dig_v[0] == dig_v[1]) && (dig_v[1] == dig_v[2]);
        pair_only = !triple && ((dig_v[0] == dig_v[1]) ||
                                (dig_v[1] == dig_v[2]) ||
                                (dig_v[0] == dig_v[2]));
    end

    // Saturating BCD score update for the current outcome.
    always_comb begin
        ones_sum   = {1'b0, ones_q} + 5'(SCORE_PAIR);
        ones_carry = (ones_sum > 5'd9);
        ones_p     = ones_carry ? 4'(ones_sum - 5'd10) : ones_sum[3:0];
        tens_sum_p = {1'b0, tens_q} + {4'd0, ones_carry};
        tens_sum_t = {1'b0, tens_q} + 5'(SCORE_TRIPLE);
        ones_nxt   = ones_q;
        tens_nxt   = tens_q;
        if (triple) begin
            if (tens_sum_t > 5'd9) begin
                ones_nxt = 4'd9;
                tens_nxt = 4'd9;
            end else begin
                tens_nxt = tens_sum_t[3:0];
            end
        end else if (pair_only) begin
            if (tens_sum_p > 5'd9) begin
                ones_nxt = 4'd9;
                tens_nxt = 4'd9;
            end else begin
                ones_nxt = ones_p;
                tens_nxt = tens_sum_p[3:0];
            end
        end
    end

    // Result flags and score: judged once in JUDGE, flags dropped when a new game starts.
    always_ff @(posedge clk or posedge i_sclr) begin
        if (i_sclr) begin
            win_q  <= 1'b0;
            pair_q <= 1'b0;
            ones_q <= 4'd0;
            tens_q <= 4'd0;
        end else if (state_q == JUDGE) begin
            win_q  <= triple;
            pair_q <= pair_only;
            ones_q <= ones_nxt;
            tens_q <= tens_nxt;
        end else if (state_q == RESULT && bus.i_stop) begin
            win_q  <= 1'b0;
            pair_q <= 1'b0;
        end
    end

    // Blink phase: starts lit on RESULT entry, toggles per tick unless leaving.
    always_ff @(posedge clk or posedge i_sclr) begin
        if (i_sclr)                                          blink_q <= 1'b0;
        else if (state_q == JUDGE)                           blink_q <= 1'b1;
        else if (state_q == RESULT && bus.i_tick && !bus.i_stop) blink_q <= ~blink_q;
    end

    // LED: steady while spinning, blinking on a jackpot result, dark otherwise.
    always_comb begin
        case (state_q)
            SPIN3, SPIN2, SPIN1: bus.o_ledr = 1'b1;
            RESULT:              bus.o_ledr = win_q & blink_q;
            default:             bus.o_ledr = 1'b0;
        endcase
    end

    assign bus.o_run        = run_v;
    assign bus.o_d0         = dig_v[0];
    assign bus.o_d1         = dig_v[1];
    assign bus.o_d2         = dig_v[2];
    assign bus.o_win        = win_q;
    assign bus.o_pair       = pair_q;
    assign bus.o_score_ones = ones_q;
    assign bus.o_score_tens = tens_q;
endmodule

// File: tb/tb_slot_judge.sv
// Scoreboarded bench for slot_judge: a driver applies per-cycle stimulus and
// pushes the outputs a game-level model predicts; a monitor pops and compares.
module tb_slot_judge;
    logic clk;
    logic i_sclr;

    slot_judge_if bus ();

    slot_judge #(.SCORE_PAIR(1), .SCORE_TRIPLE(1)) dut (
        .clk    (clk),
        .i_sclr (i_sclr),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] run;
        logic [3:0] d0, d1, d2;
        logic       win, pair, ledr;
        logic [3:0] ones, tens;
    } exp_t;

    exp_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc        = 0;

    // Game-level model: mode 0 idle, 1 spinning, 2 judging, 3 showing result.
    int mode, stopped, score;
    int dig[3];
    bit win, pair, blink;

    function automatic void model_reset();
        mode = 0; stopped = 0; score = 0;
        dig[0] = 0; dig[1] = 0; dig[2] = 0;
        win = 0; pair = 0; blink = 0;
    endfunction

    function automatic exp_t model_out(bit stop);
        exp_t e;
        for (int k = 0; k < 3; k++)
            e.run[k] = (mode == 1) && (k >= stopped) && !(stop && k == stopped);
        e.d0   = 4'(dig[0]);
        e.d1   = 4'(dig[1]);
        e.d2   = 4'(dig[2]);
        e.win  = win;
        e.pair = pair;
        e.ledr = (mode == 1) || (mode == 3 && win && blink);
        e.ones = 4'(score % 10);
        e.tens = 4'(score / 10);
        return e;
    endfunction

    function automatic void model_step(bit stop, bit tick, int c0, int c1, int c2);
        int cin[3];
        int eq;
        cin[0] = c0; cin[1] = c1; cin[2] = c2;
        case (mode)
            0: if (stop) begin mode = 1; stopped = 0; end
            1: if (stop) begin
                dig[stopped] = cin[stopped];
                stopped++;
                if (stopped == 3) mode = 2;
            end
            2: begin
                eq = int'(dig[0] == dig[1]) + int'(dig[1] == dig[2]) + int'(dig[0] == dig[2]);
                win = (eq == 3);
                pair = (eq == 1);
                if (win)  score = score + 10;
                if (pair) score = score + 1;
                if (score > 99) score = 99;
                blink = 1;
                mode = 3;
            end
            default: begin
                if (stop) begin
                    mode = 1; stopped = 0; win = 0; pair = 0;
                end else if (tick) begin
                    blink = !blink;
                end
            end
        endcase
    endfunction

    function automatic logic [3:0] rnd_digit();
        return 4'($urandom_range(0, 9));
    endfunction

    task automatic cycle(input bit rst, input bit stop, input bit tick,
                         input logic [3:0] c0, input logic [3:0] c1, input logic [3:0] c2);
        @(negedge clk);
        i_sclr     = rst;
        bus.i_stop = stop;
        bus.i_tick = tick;
        bus.i_cnt0 = c0;
        bus.i_cnt1 = c1;
        bus.i_cnt2 = c2;
        if (rst) begin
            model_reset();
            exp_q.push_back(model_out(1'b0));
        end else begin
            exp_q.push_back(model_out(stop));
            model_step(stop, tick, int'(c0), int'(c1), int'(c2));
        end
    endtask

    task automatic idle_cycle(input bit tick);
        cycle(0, 0, tick, rnd_digit(), rnd_digit(), rnd_digit());
    endtask

    // One full game from IDLE or RESULT: start, stop a/b/c, judge, show result.
    task automatic play(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input bit judge_stop, input int ticks);
        cycle(0, 1, 0, rnd_digit(), rnd_digit(), rnd_digit());
        repeat ($urandom_range(0, 2)) idle_cycle(1'($urandom_range(0, 1)));
        cycle(0, 1, 1, a, rnd_digit(), rnd_digit());
        idle_cycle(0);
        cycle(0, 1, 0, rnd_digit(), b, rnd_digit());
        cycle(0, 1, 0, rnd_digit(), rnd_digit(), c);
        cycle(0, judge_stop, 0, rnd_digit(), rnd_digit(), rnd_digit());
        for (int i = 0; i < ticks; i++) begin
            idle_cycle(1);
            idle_cycle(0);
        end
        idle_cycle(0);
    endtask

    // Monitor: compare the DUT against the oldest prediction each cycle.
    initial begin
        exp_t e, a;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {bus.o_run, bus.o_d0, bus.o_d1, bus.o_d2, bus.o_win, bus.o_pair,
                     bus.o_ledr, bus.o_score_ones, bus.o_score_tens};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL outputs cyc=%0d got run=%b d=%0d,%0d,%0d win=%b pair=%b led=%b score=%0d%0d want run=%b d=%0d,%0d,%0d win=%b pair=%b led=%b score=%0d%0d",
                             cyc, a.run, a.d0, a.d1, a.d2, a.win, a.pair, a.ledr, a.tens, a.ones,
                             e.run, e.d0, e.d1, e.d2, e.win, e.pair, e.ledr, e.tens, e.ones);
                end
                cyc++;
            end
        end
    end

    // Driver: directed games, async reset mid-game, then random stimulus.
    initial begin
        exp_t a;
        i_sclr     = 1'b1;
        bus.i_stop = 1'b0;
        bus.i_tick = 1'b0;
        bus.i_cnt0 = 4'd0;
        bus.i_cnt1 = 4'd0;
        bus.i_cnt2 = 4'd0;
        model_reset();

        repeat (3) cycle(1, 0, 0, 4'd0, 4'd0, 4'd0);
        repeat (2) idle_cycle(1);

        play(4'd5, 4'd5, 4'd5, 0, 3);      // jackpot: score 10, blinking LED
        play(4'd2, 4'd8, 4'd2, 0, 1);      // pair: score 11, LED dark
        repeat (8) play(rnd_digit(), 4'd12, 4'd12, 0, 0); // pairs up to 19
        play(4'd3, 4'd3, 4'd6, 0, 0);      // 19 -> 20 with carry
        play(4'd1, 4'd2, 4'd3, 0, 1);      // no match
        play(4'd7, 4'd7, 4'd7, 1, 0);      // stop in JUDGE ignored
        repeat (6) play(4'd9, 4'd9, 4'd9, 0, 0); // triples up to 90
        repeat (5) play(4'd0, 4'd4, 4'd4, 0, 0); // pairs up to 95
        play(4'd15, 4'd15, 4'd15, 0, 2);   // 95 + triple saturates at 99
        play(4'd6, 4'd1, 4'd6, 0, 0);      // 99 + pair stays 99

        // Reset mid-SPIN2 with reel 0 latched at 7; outputs must clear before the next edge.
        cycle(0, 1, 0, rnd_digit(), rnd_digit(), rnd_digit());
        cycle(0, 1, 0, 4'd7, rnd_digit(), rnd_digit());
        idle_cycle(0);
        #2;
        i_sclr = 1'b1;
        #1;
        a = {bus.o_run, bus.o_d0, bus.o_d1, bus.o_d2, bus.o_win, bus.o_pair,
             bus.o_ledr, bus.o_score_ones, bus.o_score_tens};
        vectors++;
        if (a !== '0) begin
            miscompares++;
            $display("FAIL async_reset got run=%b d0=%0d led=%b score=%0d%0d want all zero",
                     a.run, a.d0, a.ledr, a.tens, a.ones);
        end
        #1;
        i_sclr = 1'b0;
        model_reset();
        idle_cycle(0);

        // Random play, with occasional digits above 9 and rare resets.
        for (int i = 0; i < 1500; i++) begin
            logic [3:0] r0, r1, r2;
            if ($urandom_range(0, 7) == 0) begin
                r0 = 4'($urandom_range(0, 15));
                r1 = 4'($urandom_range(0, 15));
                r2 = 4'($urandom_range(0, 15));
            end else begin
                r0 = 4'($urandom_range(0, 2));
                r1 = 4'($urandom_range(0, 2));
                r2 = 4'($urandom_range(0, 2));
            end
            cycle($urandom_range(0, 249) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 2) == 0, r0, r1, r2);
        end

        cycle(0, 0, 0, 4'd0, 4'd0, 4'd0);
        repeat (2) @(negedge clk);
        #2;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
